pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised valid/ready pipeline stage register replacing the fixed per-boundary registers between IF/ID/EX/MEM/WB. Carries an opaque payload plus a control field that is zeroed whenever a bubble is created. Provides hazard stall, branch/jump flush and downstream backpressure. An optional skid slot lets `in_ready` be driven from a register.

## Interface
- `DATA_W`, default 160: payload width (PC, operands, immediate, register indices).
- `CTRL_W`, default 12: control width (regWrite, memRead, memWrite, branch, jump, aluOp, …); zeroed on bubble.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `flush`  in  1: kill all held and incoming beats (branch taken / jump).
- `stall`  in  1: hazard stall; blocks input acceptance only.
- `in_valid`  in  1: upstream beat valid.
- `in_ready`  out  1: stage accepts a beat this cycle.
- `in_data`  in  DATA_W: upstream payload.
- `in_ctrl`  in  CTRL_W: upstream control.
- `out_valid`  out  1: stage holds a valid beat.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  DATA_W: held payload.
- `out_ctrl`  out  CTRL_W: held control; all-zero whenever `out_valid`=0.

## Operation
- Accept: `in_valid & in_ready`. Deliver: `out_valid & out_ready`.
- Main register states: EMPTY (`out_valid`=0), FULL (`out_valid`=1). With skid: SKID (main and skid both full).
- Without skid: `in_ready = ~stall & (~out_valid | out_ready)` (combinational). EMPTY→FULL on accept; FULL→FULL on accept+deliver; FULL→EMPTY on deliver without accept.
- With skid: `in_ready = ~stall & ~skid_valid`. Accept while FULL and no deliver → beat goes to skid, state SKID. On deliver in SKID, skid moves to main, state FULL. Accept and deliver in SKID cannot coincide.
- Stall: no beat accepted. The output side keeps draining, so a bubble propagates downstream. Held beats are never cleared by stall.
- Flush: on that edge every state goes to EMPTY. `out_ctrl` and the skid control are zeroed. An incoming beat in the same cycle is discarded. `out_data` keeps its old value (don't-care).
- Priority: reset > flush > deliver/accept. Flush+stall behaves as flush.
- Order is preserved. No beat is duplicated or dropped except by flush.

## Timing
- Latency: accept at edge N → `out_valid` at N+1 (1 cycle). Skid path adds one cycle only under backpressure.
- Throughput: 1 beat/cycle when `out_ready`=1 and `stall`=0.
- Reset values: `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid empty.
- `in_ready` after reset = `~stall`.
- Reset asserted mid-transfer clears state immediately, asynchronously. The first accept happens on the first edge after deassertion.
- Without skid, `out_ready`→`in_ready` is a combinational path. With skid, `in_ready` depends only on registered state and `stall`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: skid slot, SKID state and registered-ready behaviour are compiled in. Area is roughly 2× DATA_W+CTRL_W flops.
- Undefined: single register with combinational `in_ready`. There is no SKID state, and skid logic must not be synthesised.

## Structure
- Shared package `pipe_pkg`: state enum (`PS_EMPTY`, `PS_FULL`, `PS_SKID`), default widths `PIPE_DATA_W`/`PIPE_CTRL_W`, control bit-position constants for the ID/EX instance.
- One sub-module: `pipe_skid_slot`. It is the load/clear/hold register used for both main and skid entries, and clears its control field on clear.

## Test plan
- Streaming: 8 beats `in_data`=1..8, `out_ready`=1, no stall → `out_data` 1..8 on consecutive cycles, first at 1 cycle after first accept.
- Backpressure: `out_ready`=0 for 3 cycles while `in_valid`=1 streams → no loss or duplication. With `PIPE_STAGE_SKID_EN`, `in_ready` falls one cycle after main fills; without it, `in_ready` falls the same cycle.
- Stall: `stall`=1 for 2 cycles mid-stream with `in_ctrl`=12'hFFF → `out_valid`=0 and `out_ctrl`=0 for 2 cycles, then the stalled beat appears unaltered.
- Flush: main (and skid) full with `out_ready`=0, pulse `flush` with `in_valid`=1 → next cycle `out_valid`=0 and `out_ctrl`=0; the incoming beat never appears.
- Reset: assert `reset`=0 asynchronously between edges while FULL → outputs read 0 before the next edge. After release, the first beat has 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the valid/ready pipeline stage registers that sit
// between the IF/ID/EX/MEM/WB boundaries.
//
// Contents:
//   ps_state_e     - stage occupancy: PS_EMPTY, PS_FULL, PS_SKID
//   PIPE_DATA_W    - default payload width (PC, operands, immediate, reg idx)
//   PIPE_CTRL_W    - default control width (zeroed whenever a bubble forms)
//   IDEX_*         - control bit positions used by the ID/EX instance
//   ps_state_of()  - derives the occupancy state from the two slot valids
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_DATA_W = 160;
  localparam int PIPE_CTRL_W = 12;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,  // main register empty, out_valid = 0
    PS_FULL  = 2'd1,  // main register holds a beat
    PS_SKID  = 2'd2   // main and skid registers both hold a beat
  } ps_state_e;

  // Control field layout of the ID/EX boundary. Other boundaries carry a
  // subset of these bits in the same positions.
  localparam int IDEX_REG_WRITE  = 0;
  localparam int IDEX_MEM_READ   = 1;
  localparam int IDEX_MEM_WRITE  = 2;
  localparam int IDEX_BRANCH     = 3;
  localparam int IDEX_JUMP       = 4;
  localparam int IDEX_ALU_OP_LSB = 5;
  localparam int IDEX_ALU_OP_W   = 4;
  localparam int IDEX_ALU_SRC    = 9;
  localparam int IDEX_MEM_TO_REG = 10;
  localparam int IDEX_LINK       = 11;

  // The skid slot can only be occupied behind a full main slot, so the skid
  // valid alone identifies PS_SKID.
  function automatic ps_state_e ps_state_of(input logic main_valid,
                                            input logic skid_valid);
    if (skid_valid) begin
      return PS_SKID;
    end else if (main_valid) begin
      return PS_FULL;
    end else begin
      return PS_EMPTY;
    end
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
//
// One beat-wide load/clear/hold register. Used for the main entry of a
// pipeline stage and, when compiled in, for its skid entry.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset (all fields to zero)
//   load     in   capture d_data/d_ctrl and mark the slot valid
//   clear    in   mark the slot empty and zero its control field;
//                 wins over load. The payload is left as is (don't-care).
//   d_data   in   [DATA_W] payload to load
//   d_ctrl   in   [CTRL_W] control to load
//   q_valid  out  slot holds a beat
//   q_data   out  [DATA_W] held payload
//   q_ctrl   out  [CTRL_W] held control, zero whenever q_valid = 0
// -----------------------------------------------------------------------------
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can leave it
    // unassigned and infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      // A bubble never carries live control bits; the payload is simply
      // ignored downstream, so it is not worth toggling.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      ctrl_d  = d_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, because out_data must read zero out
      // of reset; a true memory array would normally be left unreset.
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge
      // values regardless of statement order.
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_ctrl  = ctrl_q;

endmodule : pipe_skid_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Valid/ready pipeline stage register for the IF/ID/EX/MEM/WB boundaries.
// Carries an opaque payload and a control field; the control field reads zero
// whenever the stage holds no beat. Handles hazard stall (blocks acceptance
// only, the output keeps draining so a bubble travels downstream), branch/jump
// flush (drops every held and incoming beat) and downstream backpressure.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   - adds a skid entry; in_ready then depends
//                                   only on registered state and stall.
//                       undefined - single entry; in_ready is combinational
//                                   from out_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   flush      in   kill all held and incoming beats on this edge
//   stall      in   hazard stall, blocks input acceptance
//   in_valid   in   upstream beat valid
//   in_ready   out  stage accepts a beat this cycle
//   in_data    in   [DATA_W] upstream payload
//   in_ctrl    in   [CTRL_W] upstream control
//   out_valid  out  stage holds a valid beat
//   out_ready  in   downstream accepts
//   out_data   out  [DATA_W] held payload
//   out_ctrl   out  [CTRL_W] held control, all-zero when out_valid = 0
//
// Priority: reset > flush > deliver/accept. flush together with stall is a
// plain flush.
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;

  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;

  logic              accept;
  logic              deliver;
  ps_state_e         state;

  assign accept  = in_valid & in_ready;
  assign deliver = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_load;
  logic              skid_clear;

  // Registered ready: a free skid entry guarantees room for one more beat
  // even if downstream stalls this very cycle.
  assign in_ready = ~stall & ~skid_valid;

  always_comb begin
    state         = ps_state_of(main_valid, skid_valid);
    main_load     = 1'b0;
    main_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    main_src_data = in_data;
    main_src_ctrl = in_ctrl;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        PS_EMPTY: main_load = accept;
        PS_FULL: begin
          if (accept && deliver) begin
            main_load = 1'b1;
          end else if (accept) begin
            // Downstream is holding: park the new beat behind the main one.
            skid_load = 1'b1;
          end else if (deliver) begin
            main_clear = 1'b1;
          end
        end
        PS_SKID: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (deliver) begin
            main_load     = 1'b1;
            skid_clear    = 1'b1;
            main_src_data = skid_data;
            main_src_ctrl = skid_ctrl;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_skid_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_data  (in_data),
    .d_ctrl  (in_ctrl),
    .q_valid (skid_valid),
    .q_data  (skid_data),
    .q_ctrl  (skid_ctrl)
  );

`else

  // Combinational ready: a full entry can take a new beat in the same cycle
  // it hands its current one downstream.
  assign in_ready = ~stall & (~main_valid | out_ready);

  always_comb begin
    state         = ps_state_of(main_valid, 1'b0);
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_src_data = in_data;
    main_src_ctrl = in_ctrl;
    if (flush) begin
      main_clear = 1'b1;
    end else begin
      case (state)
        PS_EMPTY: main_load = accept;
        PS_FULL: begin
          if (accept) begin
            main_load = 1'b1;
          end else if (deliver) begin
            main_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`endif

  pipe_skid_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_data  (main_src_data),
    .d_ctrl  (main_src_ctrl),
    .q_valid (main_valid),
    .q_data  (main_data),
    .q_ctrl  (main_ctrl)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. A queue-based reference model holds
// the beats the stage should currently contain (capacity 1, or 2 with
// PIPE_STAGE_SKID_EN). Table vectors cover streaming and stall, hand-written
// sequences cover backpressure, flush and asynchronous reset, and a random
// phase exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 160;
  localparam int CTRL_W = 12;
`ifdef PIPE_STAGE_SKID_EN
  localparam int  CAP     = 2;
  localparam bit  SKID_ON = 1'b1;
`else
  localparam int  CAP     = 1;
  localparam bit  SKID_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              stall;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, DATA_W'(act), DATA_W'(exp));
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t mq[$];

  // Room for a beat: below capacity, or (single entry only) the held beat
  // leaves this cycle.
  function automatic bit model_ready(input bit st, input bit ordy);
    if (st) return 1'b0;
    if (mq.size() < CAP) return 1'b1;
    return (CAP == 1) && ordy;
  endfunction

  task automatic check_outputs(input string tag);
    bit have;
    have = (mq.size() > 0);
    check1({tag, ".out_valid"}, out_valid, have);
    check({tag, ".out_ctrl"}, DATA_W'(out_ctrl), have ? DATA_W'(mq[0].c) : '0);
    if (have) check({tag, ".out_data"}, out_data, mq[0].d);
  endtask

  // Drive one cycle starting just after a rising edge; returns the in_ready
  // seen before the edge. Ends one time unit after the next rising edge.
  task automatic step(input bit st, input bit fl, input bit iv, input bit ordy,
                      input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input string tag, output bit rdy_seen);
    bit    exp_rdy, dlv, acc;
    beat_t b;
    stall = st; flush = fl; in_valid = iv; out_ready = ordy;
    in_data = d; in_ctrl = c;
    #1;
    rdy_seen = in_ready;
    exp_rdy  = model_ready(st, ordy);
    check1({tag, ".in_ready"}, in_ready, exp_rdy);
    if (fl) begin
      mq.delete();
    end else begin
      dlv = (mq.size() > 0) && ordy;
      acc = iv && exp_rdy;
      if (dlv) void'(mq.pop_front());
      if (acc) begin
        b.d = d;
        b.c = c;
        mq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    bit          st, fl, iv, ordy;
    logic [7:0]  d;
    logic [11:0] c;
    bit          e_rdy, e_ov;
    logic [7:0]  e_d;
    logic [11:0] e_c;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit                rdy;
    logic [DATA_W-1:0] src;
    string             tag;

    // Streaming 1..8, then drain, then a two-cycle stall mid-stream.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{st: 1'b0, fl: 1'b0, iv: 1'b1, ordy: 1'b1, d: 8'(i + 1),
                  c: 12'(i + 1), e_rdy: 1'b1, e_ov: 1'b1, e_d: 8'(i + 1),
                  e_c: 12'(i + 1)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'h000, 1'b1, 1'b0, 8'h00, 12'h000};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 12'h009, 1'b1, 1'b1, 8'h09, 12'h009};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 12'hFFF, 1'b0, 1'b0, 8'h00, 12'h000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 12'hFFF, 1'b0, 1'b0, 8'h00, 12'h000};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 12'hFFF, 1'b1, 1'b1, 8'h0A, 12'hFFF};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'h000, 1'b1, 1'b0, 8'h00, 12'h000};

    // ---------------- reset state ----------------
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0; in_ctrl = '0;
    #1 reset = 1'b0;
    #1;
    check1("rst.out_valid", out_valid, 1'b0);
    check("rst.out_ctrl", DATA_W'(out_ctrl), '0);
    check("rst.out_data", out_data, '0);
    check1("rst.in_ready", in_ready, 1'b1);
    stall = 1'b1;
    #1;
    check1("rst.in_ready_stall", in_ready, 1'b0);
    stall = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // ---------------- table: streaming and stall ----------------
    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("vec%0d", i);
      step(vecs[i].st, vecs[i].fl, vecs[i].iv, vecs[i].ordy,
           DATA_W'(vecs[i].d), vecs[i].c, tag, rdy);
      check1({tag, ".c_in_ready"}, rdy, vecs[i].e_rdy);
      check1({tag, ".c_out_valid"}, out_valid, vecs[i].e_ov);
      check({tag, ".c_out_ctrl"}, DATA_W'(out_ctrl), DATA_W'(vecs[i].e_c));
      if (vecs[i].e_ov)
        check({tag, ".c_out_data"}, out_data, DATA_W'(vecs[i].e_d));
    end

    // ---------------- backpressure ----------------
    src = DATA_W'(8'h21);
    step(1'b0, 1'b0, 1'b1, 1'b0, src, 12'h021, "bp0", rdy);
    if (rdy) src++;
    check("bp0.c_out_data", out_data, DATA_W'(8'h21));
    step(1'b0, 1'b0, 1'b1, 1'b0, src, CTRL_W'(src), "bp1", rdy);
    check1("bp1.c_in_ready", rdy, SKID_ON);
    if (rdy) src++;
    step(1'b0, 1'b0, 1'b1, 1'b0, src, CTRL_W'(src), "bp2", rdy);
    check1("bp2.c_in_ready", rdy, 1'b0);
    check("bp2.c_out_data", out_data, DATA_W'(8'h21));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, src, CTRL_W'(src), $sformatf("bp_run%0d", i), rdy);
      if (rdy) src++;
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, $sformatf("bp_drain%0d", i), rdy);
    check1("bp.c_empty", out_valid, 1'b0);

    // ---------------- flush ----------------
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(8'h40 + i), 12'hFFF,
           $sformatf("fl_fill%0d", i), rdy);
    step(1'b0, 1'b1, 1'b1, 1'b0, DATA_W'(8'h99), 12'hFFF, "fl", rdy);
    check1("fl.c_out_valid", out_valid, 1'b0);
    check("fl.c_out_ctrl", DATA_W'(out_ctrl), '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, $sformatf("fl_after%0d", i), rdy);
      check1($sformatf("fl_after%0d.c_out_valid", i), out_valid, 1'b0);
    end

    // ---------------- asynchronous reset while full ----------------
    step(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(8'h55), 12'hFFF, "ar_fill", rdy);
    check1("ar_fill.c_out_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    mq.delete();
    check1("ar.c_out_valid", out_valid, 1'b0);
    check("ar.c_out_ctrl", DATA_W'(out_ctrl), '0);
    check("ar.c_out_data", out_data, '0);
    in_valid = 1'b1; in_data = DATA_W'(8'h77); in_ctrl = 12'h077;
    @(posedge clk);
    #1;
    check1("ar_held.c_out_valid", out_valid, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, DATA_W'(8'h66), 12'h066, "ar_first", rdy);
    check1("ar_first.c_out_valid", out_valid, 1'b1);
    check("ar_first.c_out_data", out_data, DATA_W'(8'h66));

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      logic [DATA_W-1:0] rd;
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step(($urandom % 5) == 0, ($urandom % 17) == 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, rd, CTRL_W'($urandom), $sformatf("rnd%0d", i), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipe_stage_reg
